// File: rtl/map_pkg.sv
// Shared definitions for the map update arbiter: cell codes, map geometry, write entry and FSM encoding.
// The CLR_PEND/CLEAR states exist only when MAP_CLEAR_EN is defined.
package map_pkg;

  localparam int unsigned MAP_W         = 900;
  localparam int unsigned CELLS_DEFAULT = 300;
  localparam int unsigned IDX_W         = 9;
  localparam int unsigned VAL_W         = 3;

  typedef enum logic [VAL_W-1:0] {
    NONE     = 3'd0,
    LINE     = 3'd1,
    TERMINAL = 3'd2,
    STAR     = 3'd3
  } cell_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [VAL_W-1:0] val;
  } wr_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1
`ifdef MAP_CLEAR_EN
    ,
    CLR_PEND = 2'd2,
    CLEAR    = 2'd3
`endif
  } arb_state_t;

  // First bit of a cell inside the flat map vector; idx < 300 keeps the result below 900.
  function automatic logic [9:0] cell_base(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} * 10'd3;
  endfunction

endpackage

// File: rtl/map_wr_fifo.sv
// Synchronous FIFO of pending {idx,val} map writes with push, pop, flush, full and empty.
// Pointers wrap naturally because DEPTH is a power of two.
module map_wr_fifo
  import map_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wr_entry_t din,
  input  logic      pop,
  input  logic      flush,
  output wr_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wr_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/map_update_arbiter.sv
// Arbitrates game-logic (A) and star-spawner (B) map writes, buffers them and commits during vblank.
// Optional full-map clear (clr_req/clr_done, CLR_PEND/CLEAR states) is built when MAP_CLEAR_EN is defined.
module map_update_arbiter
  import map_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CELLS      = CELLS_DEFAULT
) (
  input  logic             div_2,
  input  logic             rst,
  input  logic             vblank,
  input  logic             req_a,
  input  logic [IDX_W-1:0] idx_a,
  input  logic [VAL_W-1:0] val_a,
  input  logic             req_b,
  input  logic [IDX_W-1:0] idx_b,
  input  logic [VAL_W-1:0] val_b,
  output logic             gnt_a,
  output logic             gnt_b,
  input  logic             clr_req,
  output logic             clr_done,
  output logic [0:MAP_W-1] map,
  output logic             fifo_full,
  output logic             err
);

  arb_state_t state;
  arb_state_t state_nx;
  logic       prefer_a;
  logic       grant_ok;
  logic       clr_block;
  logic       accept;
  logic       take_in_range;
  logic       push;
  logic       pop_en;
  logic       clear_now;
  logic       fifo_empty;
  wr_entry_t  take;
  wr_entry_t  head;

`ifdef MAP_CLEAR_EN
  assign clr_block = (state == CLR_PEND) || (state == CLEAR);
  assign clr_done  = (state == CLEAR);
`else
  logic unused_clr_req;
  assign unused_clr_req = clr_req;
  assign clr_block      = 1'b0;
  assign clr_done       = 1'b0;
`endif

  // Grants are held low during reset so a stalled requester never sees a stray accept.
  assign grant_ok = !rst && !fifo_full && !clr_block;
  assign gnt_a    = grant_ok && req_a && (prefer_a || !req_b);
  assign gnt_b    = grant_ok && req_b && (!prefer_a || !req_a);
  assign accept   = gnt_a || gnt_b;

  always_comb begin
    take = '{idx: idx_b, val: val_b};
    if (gnt_a) take = '{idx: idx_a, val: val_a};
  end

  assign take_in_range = (32'(take.idx) < CELLS);
  assign push          = accept && take_in_range;

  map_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (div_2),
    .rst   (rst),
    .push  (push),
    .din   (take),
    .pop   (pop_en),
    .flush (clear_now),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge div_2 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Popping starts on the IDLE->DRAIN edge so every vblank cycle with data commits one entry.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx  = state;
    pop_en    = 1'b0;
    clear_now = 1'b0;
    case (state)
      IDLE: begin
        if (vblank && !fifo_empty) begin
          state_nx = DRAIN;
          pop_en   = 1'b1;
        end
      end
      DRAIN: begin
        if (!vblank || fifo_empty) state_nx = IDLE;
        else                       pop_en   = 1'b1;
      end
`ifdef MAP_CLEAR_EN
      CLR_PEND: begin
        if (vblank) begin
          state_nx  = CLEAR;
          clear_now = 1'b1;
        end
      end
      CLEAR: state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
`ifdef MAP_CLEAR_EN
    // A clear outranks draining; a repeat request while already pending is absorbed.
    if (clr_req && (state != CLR_PEND)) begin
      state_nx  = CLR_PEND;
      pop_en    = 1'b0;
      clear_now = 1'b0;
    end
`endif
  end

  always_ff @(posedge div_2 or posedge rst) begin
    if (rst) begin
      prefer_a <= 1'b1;
      err      <= 1'b0;
    end else begin
      if (accept) prefer_a <= gnt_b;
      err <= accept && !take_in_range;
    end
  end

  always_ff @(posedge div_2 or posedge rst) begin
    if (rst) begin
      map <= '0;
    end else if (clear_now) begin
      map <= '0;
    end else if (pop_en) begin
      map[cell_base(head.idx) +: VAL_W] <= head.val;
    end
  end

endmodule

// File: tb/tb_map_update_arbiter.sv
// Directed bench for map_update_arbiter: reset, single write, round-robin fill, range drop, split drain,
// clear (MAP_CLEAR_EN) or clear-ignored (default), and reset during drain.
module tb_map_update_arbiter;
  import map_pkg::*;

  logic             div_2 = 1'b0;
  logic             rst = 1'b0;
  logic             vblank, req_a, req_b, clr_req;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic [VAL_W-1:0] val_a, val_b;
  logic             gnt_a, gnt_b, clr_done, fifo_full, err;
  logic [0:MAP_W-1] map;
  logic [0:MAP_W-1] exp_map;
  int               checks = 0;
  int               failures = 0;
  int               n;

  typedef struct {
    logic             req_a;
    logic             req_b;
    logic [IDX_W-1:0] idx_a;
    logic [VAL_W-1:0] val_a;
    logic [IDX_W-1:0] idx_b;
    logic [VAL_W-1:0] val_b;
    logic             exp_ga;
    logic             exp_gb;
    logic             exp_full;
  } vec_t;

  vec_t vecs [6];

  always #5 div_2 = ~div_2;

  map_update_arbiter #(
    .FIFO_DEPTH (4),
    .CELLS      (300)
  ) dut (
    .div_2     (div_2),
    .rst       (rst),
    .vblank    (vblank),
    .req_a     (req_a),
    .idx_a     (idx_a),
    .val_a     (val_a),
    .req_b     (req_b),
    .idx_b     (idx_b),
    .val_b     (val_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .clr_req   (clr_req),
    .clr_done  (clr_done),
    .map       (map),
    .fifo_full (fifo_full),
    .err       (err)
  );

  task automatic tick();
    @(posedge div_2);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_map(input string name);
    checks++;
    if (map !== exp_map) begin
      failures++;
      for (int i = 0; i < 300; i++) begin
        if (map[i*3 +: 3] !== exp_map[i*3 +: 3]) begin
          $display("FAIL %s: cell %0d got %0d expected %0d", name, i, map[i*3 +: 3], exp_map[i*3 +: 3]);
          break;
        end
      end
    end
  endtask

  task automatic set_cell(input int i, input logic [2:0] v);
    exp_map[i*3 +: 3] = v;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 9'd21,  3'd2, 9'd22,  3'd2, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 9'd40,  3'd3, 9'd22,  3'd2, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 9'd40,  3'd3, 9'd299, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 9'd5,   3'd1, 9'd299, 3'd3, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 9'd5,   3'd1, 9'd7,   3'd1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 9'd5,   3'd1, 9'd7,   3'd1, 1'b0, 1'b0, 1'b1};

    exp_map = '0;
    vblank = 1'b0; clr_req = 1'b0;
    req_a = 1'b1; req_b = 1'b1;
    idx_a = '0; val_a = '0; idx_b = '0; val_b = '0;

    // Reset state, with both requests raised to prove grants stay low.
    #1 rst = 1'b1;
    #1;
    check("rst_gnt_a", gnt_a, 0);
    check("rst_gnt_b", gnt_b, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_err", err, 0);
    check("rst_clr_done", clr_done, 0);
    check_map("rst_map");
    tick();
    tick();
    req_a = 1'b0; req_b = 1'b0;
    rst = 1'b0;
    tick();

    // Single A write: one-cycle grant, no commit until vblank, then cell 21 bits 63..65.
    req_a = 1'b1; idx_a = 9'd21; val_a = 3'd1;
    #1;
    check("single_gnt_a", gnt_a, 1);
    check("single_gnt_b", gnt_b, 0);
    tick();
    req_a = 1'b0;
    #1;
    check("single_gnt_drop", gnt_a, 0);
    tick();
    tick();
    check_map("no_commit_without_vblank");
    vblank = 1'b1;
    tick();
    set_cell(21, 3'd1);
    check("cell21_bits", map[63:65], 3'b001);
    check_map("single_commit");
    vblank = 1'b0;
    tick();

    // B write to idx 300: granted, dropped, err next cycle only.
    req_b = 1'b1; idx_b = 9'd300; val_b = 3'd3;
    #1;
    check("oor_gnt_b", gnt_b, 1);
    check("oor_err_before", err, 0);
    tick();
    req_b = 1'b0;
    #1;
    check("oor_err_pulse", err, 1);
    tick();
    check("oor_err_clear", err, 0);
    vblank = 1'b1;
    tick();
    tick();
    check_map("oor_map_unchanged");
    vblank = 1'b0;
    tick();

    // Round-robin fill with both requesting; full after exactly four accepts.
    for (int i = 0; i < 6; i++) begin
      req_a = vecs[i].req_a; idx_a = vecs[i].idx_a; val_a = vecs[i].val_a;
      req_b = vecs[i].req_b; idx_b = vecs[i].idx_b; val_b = vecs[i].val_b;
      #1;
      check($sformatf("rr%0d_gnt_a", i), gnt_a, vecs[i].exp_ga);
      check($sformatf("rr%0d_gnt_b", i), gnt_b, vecs[i].exp_gb);
      check($sformatf("rr%0d_full", i), fifo_full, vecs[i].exp_full);
      check($sformatf("rr%0d_err", i), err, 0);
      tick();
    end
    req_a = 1'b0; req_b = 1'b0;

    // Two vblank cycles commit the two oldest entries only.
    vblank = 1'b1;
    tick();
    tick();
    vblank = 1'b0;
    set_cell(21, 3'd2);
    set_cell(22, 3'd2);
    check_map("drain_two");
    check("drain_two_not_full", fifo_full, 0);
    tick();
    tick();
    check_map("hold_between_vblanks");

    // Next vblank: push during drain, remaining entries commit in order.
    vblank = 1'b1;
    req_a = 1'b1; idx_a = 9'd100; val_a = 3'd1;
    #1;
    check("push_during_drain_gnt", gnt_a, 1);
    tick();
    req_a = 1'b0;
    #1;
    check("push_pop_not_full", fifo_full, 0);
    tick();
    tick();
    tick();
    vblank = 1'b0;
    set_cell(40, 3'd3);
    set_cell(299, 3'd3);
    set_cell(100, 3'd1);
    check_map("drain_rest");
    tick();

`ifdef MAP_CLEAR_EN
    // Clear with three entries pending: no grants while pending, one clr_done, map and FIFO emptied.
    req_a = 1'b1; idx_a = 9'd50; val_a = 3'd1;
    #1;
    check("pre_clear_gnt", gnt_a, 1);
    tick();
    idx_a = 9'd51; val_a = 3'd2;
    tick();
    idx_a = 9'd52; val_a = 3'd3;
    tick();
    req_a = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    req_a = 1'b1; idx_a = 9'd60; val_a = 3'd1;
    #1;
    check("clr_pend_no_gnt", gnt_a, 0);
    check("clr_pend_no_done", clr_done, 0);
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    #1;
    check("clr_pend_no_gnt2", gnt_a, 0);
    req_a = 1'b0;
    check_map("pre_clear_map");
    vblank = 1'b1;
    n = 0;
    exp_map = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) begin
        check("clear_done_pulse", clr_done, 1);
        check_map("clear_map_zero");
      end
      n += int'(clr_done);
    end
    check("clr_done_once", n, 1);
    check_map("clear_fifo_flushed");
    vblank = 1'b0;
    tick();
`else
    // Clear disabled: clr_req is ignored, grants continue, writes commit, clr_done never rises.
    req_a = 1'b1; idx_a = 9'd50; val_a = 3'd1;
    clr_req = 1'b1;
    #1;
    check("clr_ignored_gnt", gnt_a, 1);
    tick();
    clr_req = 1'b0;
    idx_a = 9'd51; val_a = 3'd2;
    tick();
    idx_a = 9'd52; val_a = 3'd3;
    tick();
    req_a = 1'b0;
    vblank = 1'b1;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n += int'(clr_done);
    end
    check("clr_done_never", n, 0);
    set_cell(50, 3'd1);
    set_cell(51, 3'd2);
    set_cell(52, 3'd3);
    check_map("commit_without_clear");
    vblank = 1'b0;
    tick();
`endif

    // Reset mid-drain with err high: everything returns to reset values, leftovers never commit.
    req_a = 1'b1; idx_a = 9'd200; val_a = 3'd1;
    tick();
    idx_a = 9'd201; val_a = 3'd2;
    tick();
    idx_a = 9'd202; val_a = 3'd3;
    tick();
    req_a = 1'b0;
    vblank = 1'b1;
    req_b = 1'b1; idx_b = 9'd400; val_b = 3'd3;
    #1;
    check("mid_drain_oor_gnt", gnt_b, 1);
    tick();
    req_b = 1'b0;
    set_cell(200, 3'd1);
    check_map("drain_before_rst");
    check("err_before_rst", err, 1);
    rst = 1'b1;
    req_a = 1'b1; idx_a = 9'd10; val_a = 3'd1;
    #1;
    exp_map = '0;
    check("mid_rst_gnt_a", gnt_a, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_full", fifo_full, 0);
    check("mid_rst_clr_done", clr_done, 0);
    check_map("mid_rst_map");
    tick();
    req_a = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    tick();
    check_map("no_commit_after_rst");
    vblank = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
